// File: rtl/dram_bank_sched_if.sv
// Request and DRAM command channels of the bank scheduler.
// master drives requests and acks; slave is the scheduler.
interface dram_bank_sched_if #(
    parameter int NUM_BANKS = 8,
    parameter int NUM_ROWS  = 128,
    parameter int NUM_COLS  = 8
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);

    logic          req_val;
    logic          req_rdy;
    logic          req_we;
    logic [BW-1:0] req_bank;
    logic [RW-1:0] req_row;
    logic [CW-1:0] req_col;
    logic          refresh_flag;
    logic          cmd_req;
    logic          cmd_ack;
    logic [1:0]    cmd;
    logic          cmd_all;
    logic          cmd_we;
    logic [BW-1:0] cmd_bank;
    logic [RW-1:0] cmd_row;
    logic [CW-1:0] cmd_col;
    logic          ref_done;
    logic          busy;

    modport master (
        output req_val, req_we, req_bank, req_row, req_col,
        output refresh_flag, cmd_ack,
        input  req_rdy, cmd_req, cmd, cmd_all, cmd_we,
        input  cmd_bank, cmd_row, cmd_col, ref_done, busy
    );

    modport slave (
        input  req_val, req_we, req_bank, req_row, req_col,
        input  refresh_flag, cmd_ack,
        output req_rdy, cmd_req, cmd, cmd_all, cmd_we,
        output cmd_bank, cmd_row, cmd_col, ref_done, busy
    );
endinterface

// File: rtl/dram_bank_sched.sv
// Single-request DRAM bank scheduler with refresh handling.
// Define DRAM_OPEN_PAGE_EN for open-page policy; default is close-page.
module dram_bank_sched #(
    parameter int NUM_BANKS = 8,
    parameter int NUM_ROWS  = 128,
    parameter int NUM_COLS  = 8,
    parameter int BURST_LEN = 8,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 8
) (
    input logic              clk,
    input logic              rst_b,
    dram_bank_sched_if.slave bus
);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int RW    = $clog2(NUM_ROWS);
    localparam int CW    = $clog2(NUM_COLS);
    localparam int TMAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMAX  = (TMAX0 > T_RFC) ? TMAX0 : T_RFC;
    localparam int CNTW  = $clog2(TMAX + 1);
    localparam int BLW   = $clog2(BURST_LEN + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_COL = 2'b01;
    localparam logic [1:0] CMD_PRE = 2'b11;
    localparam logic [1:0] CMD_REF = 2'b10;

    typedef enum logic [3:0] {
        IDLE, PRE, WAIT_RP, ACT, WAIT_RCD,
        COL, PREA, REF, WAIT_RFC
    } state_t;

    state_t           state, state_d;
    logic             we_q;
    logic [BW-1:0]    bank_q;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic [BLW-1:0]   beat;
    logic [CNTW-1:0]  cnt;
    logic             ref_q;
    logic [NUM_BANKS-1:0] open_q;
    logic             fire;
    logic             last;
    logic             cnt_done;

    assign fire     = bus.cmd_req && bus.cmd_ack;
    assign last     = beat == BLW'(BURST_LEN - 1);
    assign cnt_done = cnt == '0;

`ifdef DRAM_OPEN_PAGE_EN
    logic [RW-1:0] open_row [NUM_BANKS];
    logic          hit;

    assign hit = open_q[bus.req_bank] &&
                 (open_row[bus.req_bank] == bus.req_row);

    always_ff @(posedge clk) begin
        if (state == ACT && fire) open_row[bank_q] <= row_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (bus.refresh_flag)
                    state_d = (|open_q) ? PREA : REF;
                else if (bus.req_val) begin
`ifdef DRAM_OPEN_PAGE_EN
                    if (hit)                         state_d = COL;
                    else if (open_q[bus.req_bank])   state_d = PRE;
                    else                             state_d = ACT;
`else
                    state_d = ACT;
`endif
                end
            end
            PRE:      if (fire) state_d = WAIT_RP;
            WAIT_RP: begin
                if (cnt_done) begin
`ifdef DRAM_OPEN_PAGE_EN
                    state_d = ref_q ? REF : ACT;
`else
                    state_d = ref_q ? REF : IDLE;
`endif
                end
            end
            ACT:      if (fire) state_d = WAIT_RCD;
            WAIT_RCD: if (cnt_done) state_d = COL;
            COL: begin
                if (fire && last) begin
`ifdef DRAM_OPEN_PAGE_EN
                    state_d = IDLE;
`else
                    state_d = PRE;
`endif
                end
            end
            PREA:     if (fire) state_d = WAIT_RP;
            REF:      if (fire) state_d = WAIT_RFC;
            WAIT_RFC: if (cnt_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Entry loads below override the free-running decrement.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            open_q <= '0;
            cnt    <= '0;
            beat   <= '0;
            ref_q  <= 1'b0;
        end else begin
            if (!cnt_done) cnt <= cnt - 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.refresh_flag) ref_q <= 1'b1;
                    else if (bus.req_val) begin
                        we_q   <= bus.req_we;
                        bank_q <= bus.req_bank;
                        row_q  <= bus.req_row;
                        col_q  <= bus.req_col;
                        beat   <= '0;
                    end
                end
                PRE: if (fire) begin
                    open_q[bank_q] <= 1'b0;
                    cnt <= CNTW'(T_RP - 1);
                end
                PREA: if (fire) begin
                    open_q <= '0;
                    cnt <= CNTW'(T_RP - 1);
                end
                ACT: if (fire) begin
                    open_q[bank_q] <= 1'b1;
                    cnt <= CNTW'(T_RCD - 1);
                end
                COL: if (fire) begin
                    beat  <= beat + 1'b1;
                    col_q <= (col_q == CW'(NUM_COLS - 1)) ?
                             '0 : col_q + CW'(1);
                end
                REF: if (fire) cnt <= CNTW'(T_RFC - 1);
                WAIT_RFC: if (cnt_done) ref_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.cmd = CMD_ACT;
        unique case (state)
            COL:       bus.cmd = CMD_COL;
            PRE, PREA: bus.cmd = CMD_PRE;
            REF:       bus.cmd = CMD_REF;
            default:   bus.cmd = CMD_ACT;
        endcase
    end

    assign bus.req_rdy  = (state == IDLE) && !bus.refresh_flag;
    assign bus.cmd_req  = state inside {PRE, ACT, COL, PREA, REF};
    assign bus.cmd_all  = state == PREA;
    assign bus.cmd_we   = we_q;
    assign bus.cmd_bank = bank_q;
    assign bus.cmd_row  = row_q;
    assign bus.cmd_col  = col_q;
    assign bus.ref_done = (state == WAIT_RFC) && cnt_done;
    assign bus.busy     = state != IDLE;
endmodule

// File: tb/tb_dram_bank_sched.sv
// Directed bench for dram_bank_sched; tracks either page policy
// through DRAM_OPEN_PAGE_EN.
module tb_dram_bank_sched;
    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    dram_bank_sched_if #(
        .NUM_BANKS(8), .NUM_ROWS(128), .NUM_COLS(8)
    ) bus ();

    dram_bank_sched #(
        .NUM_BANKS(8), .NUM_ROWS(128), .NUM_COLS(8),
        .BURST_LEN(8), .T_RCD(2), .T_RP(2), .T_RFC(8)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .bus(bus)
    );

    typedef struct packed {
        logic       c;
        logic [1:0] cmd;
        logic       all;
        logic       we;
        logic [2:0] bank;
        logic [6:0] row;
        logic [2:0] col;
    } ent_t;

    ent_t trace[$];
    ent_t exp_q[$];
    int total = 0;
    int passed = 0;

    function automatic ent_t mk(input logic [1:0] cmd, input logic all,
                                input logic we, input logic [2:0] bank,
                                input logic [6:0] row, input logic [2:0] col);
        ent_t e;
        e = '{c: 1'b1, cmd: cmd, all: all, we: we,
              bank: bank, row: row, col: col};
        return e;
    endfunction

    // Command fields that matter for each command kind; others zeroed.
    function automatic ent_t obs();
        ent_t e;
        e = '0;
        if (bus.cmd_req) begin
            e.c = 1'b1;
            e.cmd = bus.cmd;
            e.all = bus.cmd_all;
            if (!bus.cmd_all && bus.cmd != 2'b10) e.bank = bus.cmd_bank;
            if (bus.cmd == 2'b00) e.row = bus.cmd_row;
            if (bus.cmd == 2'b01) begin
                e.we = bus.cmd_we;
                e.col = bus.cmd_col;
            end
        end
        return e;
    endfunction

    task automatic add_wait(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('0);
    endtask

    task automatic add_cols(input logic we, input logic [2:0] bank,
                            input logic [2:0] start);
        logic [2:0] c;
        c = start;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(2'b01, 1'b0, we, bank, 7'd0, c));
            c = c + 3'd1;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] b,
                         input logic [6:0] r, input logic [2:0] c,
                         output bit ok);
        @(negedge clk);
        bus.req_we = we;
        bus.req_bank = b;
        bus.req_row = r;
        bus.req_col = c;
        bus.req_val = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.req_val = 1'b0;
    endtask

    task automatic capture(output bit ok);
        trace.delete();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            trace.push_back(obs());
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy);
        else passed++;
        total++;
        if (bus.cmd_req !== 1'b0) $display("FAIL rst_cmd_req got %b want 0", bus.cmd_req);
        else passed++;
        total++;
        if (bus.ref_done !== 1'b0) $display("FAIL rst_ref_done got %b want 0", bus.ref_done);
        else passed++;
        total++;
        if (bus.req_rdy !== 1'b1) $display("FAIL rst_req_rdy got %b want 1", bus.req_rdy);
        else passed++;
        bus.refresh_flag = 1'b1;
        #1;
        total++;
        if (bus.req_rdy !== 1'b0) $display("FAIL rst_rdy_ref got %b want 0", bus.req_rdy);
        else passed++;
        bus.refresh_flag = 1'b0;
        rst_b = 1'b1;
    endtask

    task automatic test_miss();
        bit ok, ok2;
        ent_t got;
        exp_q.delete();
        exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 3'd2, 7'd5, 3'd0));
        add_wait(2);
        add_cols(1'b0, 3'd2, 3'd0);
`ifndef DRAM_OPEN_PAGE_EN
        exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 3'd2, 7'd0, 3'd0));
        add_wait(2);
`endif
        issue(1'b0, 3'd2, 7'd5, 3'd0, ok);
        capture(ok2);
        total++;
        if (!ok || !ok2 || trace.size() != exp_q.size())
            $display("FAIL miss_len got %0d want %0d", trace.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = '1;
            if (i < trace.size()) got = trace[i];
            total++;
            if (got !== exp_q[i])
                $display("FAIL miss_cmd[%0d] got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_hit();
        bit ok, ok2;
        ent_t got;
        exp_q.delete();
`ifndef DRAM_OPEN_PAGE_EN
        exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 3'd2, 7'd5, 3'd0));
        add_wait(2);
`endif
        add_cols(1'b0, 3'd2, 3'd6);
`ifndef DRAM_OPEN_PAGE_EN
        exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 3'd2, 7'd0, 3'd0));
        add_wait(2);
`endif
        issue(1'b0, 3'd2, 7'd5, 3'd6, ok);
        capture(ok2);
        total++;
        if (!ok || !ok2 || trace.size() != exp_q.size())
            $display("FAIL hit_len got %0d want %0d", trace.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = '1;
            if (i < trace.size()) got = trace[i];
            total++;
            if (got !== exp_q[i])
                $display("FAIL hit_cmd[%0d] got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_conflict();
        bit ok, ok2;
        ent_t got;
        exp_q.delete();
`ifdef DRAM_OPEN_PAGE_EN
        exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 3'd2, 7'd0, 3'd0));
        add_wait(2);
`endif
        exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 3'd2, 7'd9, 3'd0));
        add_wait(2);
        add_cols(1'b1, 3'd2, 3'd0);
`ifndef DRAM_OPEN_PAGE_EN
        exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 3'd2, 7'd0, 3'd0));
        add_wait(2);
`endif
        issue(1'b1, 3'd2, 7'd9, 3'd0, ok);
        capture(ok2);
        total++;
        if (!ok || !ok2 || trace.size() != exp_q.size())
            $display("FAIL conf_len got %0d want %0d", trace.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = '1;
            if (i < trace.size()) got = trace[i];
            total++;
            if (got !== exp_q[i])
                $display("FAIL conf_cmd[%0d] got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_refresh();
        bit ok;
        int n_done, done_at, rdy_bad;
        ent_t got;
        exp_q.delete();
`ifdef DRAM_OPEN_PAGE_EN
        exp_q.push_back(mk(2'b11, 1'b1, 1'b0, 3'd0, 7'd0, 3'd0));
        add_wait(2);
`endif
        exp_q.push_back(mk(2'b10, 1'b0, 1'b0, 3'd0, 7'd0, 3'd0));
        add_wait(8);
        @(negedge clk);
        bus.refresh_flag = 1'b1;
        bus.req_we = 1'b0;
        bus.req_bank = 3'd1;
        bus.req_row = 7'd3;
        bus.req_col = 3'd2;
        bus.req_val = 1'b1;
        #1;
        total++;
        if (bus.req_rdy !== 1'b0) $display("FAIL ref_rdy got %b want 0", bus.req_rdy);
        else passed++;
        trace.delete();
        n_done = 0;
        done_at = -1;
        rdy_bad = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_rdy) rdy_bad++;
            trace.push_back(obs());
            if (bus.ref_done) begin
                n_done++;
                done_at = i;
                bus.refresh_flag = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || trace.size() != exp_q.size())
            $display("FAIL ref_len got %0d want %0d", trace.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) begin
            got = '1;
            if (i < trace.size()) got = trace[i];
            total++;
            if (got !== exp_q[i])
                $display("FAIL ref_cmd[%0d] got %h want %h", i, got, exp_q[i]);
            else passed++;
        end
        total++;
        if (done_at != exp_q.size() - 1)
            $display("FAIL ref_done_at got %0d want %0d", done_at, exp_q.size() - 1);
        else passed++;
        total++;
        if (rdy_bad != 0) $display("FAIL ref_rdy_hold got %0d want 0", rdy_bad);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.ref_done !== 1'b0 || bus.req_rdy !== 1'b1)
            $display("FAIL ref_pulse got done=%b rdy=%b want done=0 rdy=1",
                     bus.ref_done, bus.req_rdy);
        else passed++;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
        @(negedge clk);
        got = obs();
        total++;
        if (got !== mk(2'b00, 1'b0, 1'b0, 3'd1, 7'd3, 3'd0))
            $display("FAIL ref_after got %h want %h", got,
                     mk(2'b00, 1'b0, 1'b0, 3'd1, 7'd3, 3'd0));
        else passed++;
        capture(ok);
        total++;
        if (!ok) $display("FAIL ref_drain got busy want idle");
        else passed++;
    endtask

    task automatic test_stall();
        bit ok, found;
        int bad;
        ent_t got;
        issue(1'b0, 3'd4, 7'd1, 3'd3, ok);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_req && bus.cmd == 2'b01) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!ok || !found || bus.cmd_col !== 3'd3)
            $display("FAIL stall_first got col=%0d found=%b want col=3", bus.cmd_col, found);
        else passed++;
        bus.cmd_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!(bus.cmd_req === 1'b1 && bus.cmd === 2'b01 &&
                  bus.cmd_col === 3'd3 && bus.cmd_bank === 3'd4))
                bad++;
        end
        total++;
        if (bad != 0) $display("FAIL stall_hold got %0d unstable want 0", bad);
        else passed++;
        bus.cmd_ack = 1'b1;
        @(negedge clk);
        total++;
        if (bus.cmd_req !== 1'b1 || bus.cmd_col !== 3'd4)
            $display("FAIL stall_next got req=%b col=%0d want req=1 col=4",
                     bus.cmd_req, bus.cmd_col);
        else passed++;
        rst_b = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.cmd_req !== 1'b0)
            $display("FAIL mid_rst got busy=%b req=%b want 0 0", bus.busy, bus.cmd_req);
        else passed++;
        rst_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cmd_req !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL post_rst_cmd got %0d cmds want 0", bad);
        else passed++;
        issue(1'b0, 3'd4, 7'd1, 3'd3, ok);
        @(negedge clk);
        got = obs();
        total++;
        if (!ok || got !== mk(2'b00, 1'b0, 1'b0, 3'd4, 7'd1, 3'd0))
            $display("FAIL post_rst_act got %h want %h", got,
                     mk(2'b00, 1'b0, 1'b0, 3'd4, 7'd1, 3'd0));
        else passed++;
        capture(ok);
        total++;
        if (!ok) $display("FAIL post_rst_drain got busy want idle");
        else passed++;
    endtask

    initial begin
        rst_b = 1'b0;
        bus.req_val = 1'b0;
        bus.req_we = 1'b0;
        bus.req_bank = '0;
        bus.req_row = '0;
        bus.req_col = '0;
        bus.refresh_flag = 1'b0;
        bus.cmd_ack = 1'b1;
        test_reset();
        test_miss();
        test_hit();
        test_conflict();
        test_refresh();
        test_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
